// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole game blocks.
package whack_pkg;

   localparam int unsigned N_HOLES_DEF            = 4;
   localparam int unsigned DEBOUNCE_CYCLES_SIM    = 16;
   localparam int unsigned DEBOUNCE_CYCLES_BOARD  = 500000;

   // Width of a hole index; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage : whack_pkg

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser followed by a stability counter that drives the clean level.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_clean
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_clean;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_clean_nxt;

   // Count while the synchronised level disagrees; flip once it has disagreed long enough.
   always_comb begin
      w_cnt_nxt   = '0;
      w_clean_nxt = r_clean;
      if (r_sync2 != r_clean) begin
         if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            w_clean_nxt = r_sync2;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   // Synchroniser, counter and clean level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_clean <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         r_cnt   <= w_cnt_nxt;
         r_clean <= w_clean_nxt;
      end
   end

   assign btn_clean = r_clean;

endmodule : button_debounce

// File: rtl/hit_detector.sv
// Debounces hole buttons, detects presses and judges them against raised moles.
module hit_detector
   import whack_pkg::*;
#(
   parameter  int unsigned N_HOLES         = N_HOLES_DEF,
   parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
   localparam int unsigned IDX_W           = idx_w(N_HOLES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               clear,
   input  logic [N_HOLES-1:0] btn_raw,
   input  logic [N_HOLES-1:0] mole_mask,
   output logic [N_HOLES-1:0] btn_clean,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic [IDX_W-1:0]   hit_hole
);

   logic [N_HOLES-1:0] w_clean;
   logic [N_HOLES-1:0] r_clean_prev;
   logic [N_HOLES-1:0] r_lock;
   logic               r_hit;
   logic               r_miss;
   logic [IDX_W-1:0]   r_hole;

   logic [N_HOLES-1:0] w_press;
   logic [N_HOLES-1:0] w_cand;
   logic [N_HOLES-1:0] w_onehot;
   logic [N_HOLES-1:0] w_lock_nxt;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_hole_nxt;
   logic               w_judge;
   logic               w_hit_nxt;
   logic               w_miss_nxt;

   // One debouncer per hole.
   for (genvar g = 0; g < int'(N_HOLES); g++) begin : g_db
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw[g]),
         .btn_clean (w_clean[g])
      );
   end

   // Press detection, lowest-index candidate select and next-state of judge registers.
   always_comb begin
      w_press  = w_clean & ~r_clean_prev;
      w_cand   = w_press & mole_mask & ~r_lock;
      w_idx    = '0;
      w_onehot = '0;
      for (int i = int'(N_HOLES) - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            w_idx       = IDX_W'(i);
            w_onehot    = '0;
            w_onehot[i] = 1'b1;
         end
      end
      w_judge    = enable & ~clear;
      w_hit_nxt  = w_judge & (|w_cand);
      w_miss_nxt = w_judge & ~(|w_cand) & (|(w_press & ~mole_mask));
      w_hole_nxt = w_hit_nxt ? w_idx : r_hole;
      // A lock lives only while its mole stays raised.
      w_lock_nxt = clear ? '0 : ((r_lock | (w_hit_nxt ? w_onehot : '0)) & mole_mask);
   end

   // Edge history, locks and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clean_prev <= '0;
         r_lock       <= '0;
         r_hit        <= 1'b0;
         r_miss       <= 1'b0;
         r_hole       <= '0;
      end else begin
         r_clean_prev <= w_clean;
         r_lock       <= w_lock_nxt;
         r_hit        <= w_hit_nxt;
         r_miss       <= w_miss_nxt;
         r_hole       <= w_hole_nxt;
      end
   end

   assign btn_clean  = w_clean;
   assign hit_pulse  = r_hit;
   assign miss_pulse = r_miss;
   assign hit_hole   = r_hole;

endmodule : hit_detector
